ep01_sweep_ctrl: RTL and testbench
==================================

# ep01_sweep_ctrl

Sequencer for the 4-input combinational function blocks (ep01-style `a,b,c,d -> f`). It walks the block through all 16 input combinations, waits a settle time on each, and samples `f` into a 16-bit truth-table register. It compares the result against an expected table and reports pass/fail, mismatch count and the first failing index. It sits between the board-level start/abort controls and a single combinational function instance.

## Interface
Parameters:
- `SETTLE`, default 1: cycles each vector is held before `f` is sampled on that vector's last cycle; legal range 1..15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a sweep; sampled only in IDLE.
- `abort`  in  1  synchronous abort of a running sweep.
- `expected`  in  16  expected truth table; bit i = expected `f` for index i; latched on start acceptance.
- `f`  in  1  output of the function block under control.
- `a`, `b`, `c`, `d`  out  1 each  drive the function block; `{a,b,c,d}` = current index, `a` is MSB.
- `busy`  out  1  high while a sweep runs.
- `done`  out  1  one-cycle pulse at completion of a full sweep.
- `table_out`  out  16  captured truth table; bit i = sampled `f` at index i.
- `mismatches`  out  5  count of bits where `table_out` differs from latched `expected` (0..16).
- `fail_valid`  out  1  at least one mismatch recorded this sweep.
- `first_fail`  out  4  lowest failing index; valid when `fail_valid`=1.
- `pass`  out  1  high after a completed sweep with `mismatches`=0; held until the next accepted start.

## Operation
- States: IDLE, RUN, DONE.
- Reset (async, immediate): state IDLE, `a..d`=0, `busy`=0, `done`=0, `table_out`=0, `mismatches`=0, `fail_valid`=0, `first_fail`=0, `pass`=0, index=0, settle counter=0.
- IDLE:
  - `start`=1 → RUN.
  - On that edge: index←0, counter←0, `expected` latched, `table_out`/`mismatches`/`fail_valid`/`first_fail`/`pass` cleared, `busy`←1.
- RUN:
  - `{a,b,c,d}` = index throughout.
  - Counter increments each cycle.
  - When counter=SETTLE−1, on that edge:
    - `table_out[index]`←`f`.
    - If `f` ≠ latched `expected[index]`: `mismatches`+1, and if `fail_valid`=0 then `first_fail`←index, `fail_valid`←1.
    - Counter←0.
    - If index=15 → DONE; otherwise index+1.
- DONE (one cycle):
  - `done`=1, `busy`=0, `pass`=(`mismatches`=0).
  - Next cycle → IDLE; `a..d` return to 0.
- `start` while RUN or DONE: ignored, no queuing.
- `abort`=1 in RUN:
  - Next edge → IDLE, `busy`←0, no `done`, `pass` stays 0.
  - `table_out`, `mismatches`, `fail_valid` and `first_fail` keep their partial values.
  - `abort` has priority over a sample scheduled on the same edge; that sample is discarded.
- `abort` in IDLE/DONE: no effect.
- `mismatches` saturates naturally at 16; no wrap is possible.

## Timing
- Start accepted at edge 0; index 0 is driven from cycle 1.
- Each vector is held exactly SETTLE cycles; index i is sampled at edge (i+1)·SETTLE.
- `done` is high in cycle 16·SETTLE+1, then `busy` stays 0.
- Minimum start-to-start spacing: 16·SETTLE+2 cycles.
- Results (`table_out`, counters, `pass`) remain stable in IDLE until the next accepted start.
- Reset asserted mid-sweep clears everything within the same cycle, asynchronously. Deassertion lands in IDLE, and a new start is needed.

## Test plan
- SETTLE=1, `f`=a&b, `expected`=16'hF000, start pulse → `busy` for 16 cycles, `done` at cycle 17, `table_out`=16'hF000, `mismatches`=0, `pass`=1, `fail_valid`=0.
- SETTLE=1, `f`=a&b, `expected`=16'hF081 → `table_out`=16'hF000, `mismatches`=2, `first_fail`=0, `fail_valid`=1, `pass`=0.
- SETTLE=3, `f`=a^b^c^d, `expected`=16'h6996 → each `{a,b,c,d}` value held 3 cycles, `done` at cycle 49, `pass`=1.
- Start re-pulsed at cycles 5 and 17 of a SETTLE=1 run → ignored, single `done` at cycle 17; a start at cycle 18 is accepted.
- `abort` at cycle 6 (SETTLE=1, `f`=1, `expected`=0) → index 5 sample discarded, `busy`=0, no `done`, `table_out`=16'h001F, `mismatches`=5, `first_fail`=0.
- `reset` asserted mid-sweep at cycle 9 → all outputs 0 immediately. After release with no start, the block stays idle. A fresh start then completes normally.

Source files
------------

// File: rtl/ep01_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ep01_sweep_ctrl
// Description : Drives a 4-input combinational function block through all 16
//               input combinations. Each vector is held SETTLE cycles and f is
//               sampled on the vector's last cycle into a 16-bit truth table.
//               The table is compared bit-by-bit against an expected table
//               latched at start, reporting mismatch count, the first failing
//               index and an overall pass flag.
// Ports       : clk, reset (async, active-high)
//               start, abort         - sweep control
//               expected[15:0]       - expected truth table (bit i = index i)
//               f                    - function-block output under test
//               a,b,c,d              - function-block inputs, {a,b,c,d}=index
//               busy, done           - sweep running / completion pulse
//               table_out[15:0]      - captured truth table
//               mismatches[4:0]      - differing bits (0..16)
//               fail_valid,
//               first_fail[3:0]      - lowest failing index when valid
//               pass                 - last complete sweep had no mismatch
// Revision    : 1.0 - initial release
// ============================================================================
module ep01_sweep_ctrl #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] expected,
    input  logic        f,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_out,
    output logic [4:0]  mismatches,
    output logic        fail_valid,
    output logic [3:0]  first_fail,
    output logic        pass
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [3:0] c_settle_last = 4'(SETTLE - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [3:0]  r_index;
    logic [3:0]  r_cnt;
    logic [15:0] r_exp;
    logic [15:0] r_table;
    logic [4:0]  r_mism;
    logic        r_fail_valid;
    logic [3:0]  r_first_fail;
    logic        r_pass;

    logic        w_accept;
    logic        w_sample;

    assign w_accept = (r_state == c_st_idle) && start;
    // Abort wins over a sample due on the same edge.
    assign w_sample = (r_state == c_st_run) && !abort && (r_cnt == c_settle_last);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (start) w_state_next = c_st_run;
            end
            c_st_run: begin
                if (abort) begin
                    w_state_next = c_st_idle;
                end else if (w_sample && (r_index == 4'hF)) begin
                    w_state_next = c_st_done;
                end
            end
            c_st_done: w_state_next = c_st_idle;
            default:   w_state_next = c_st_idle;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        busy = (r_state == c_st_run);
        done = (r_state == c_st_done);
        // Vector lines only follow the index while a sweep is in flight so an
        // aborted sweep leaves the function block parked at 0.
        if ((r_state == c_st_run) || (r_state == c_st_done)) begin
            {a, b, c, d} = r_index;
        end else begin
            {a, b, c, d} = 4'd0;
        end
        // The done cycle shows the verdict before r_pass is updated on exit.
        pass = r_pass || ((r_state == c_st_done) && (r_mism == 5'd0));
    end

    assign table_out  = r_table;
    assign mismatches = r_mism;
    assign fail_valid = r_fail_valid;
    assign first_fail = r_first_fail;

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_index      <= 4'd0;
            r_cnt        <= 4'd0;
            r_exp        <= 16'd0;
            r_table      <= 16'd0;
            r_mism       <= 5'd0;
            r_fail_valid <= 1'b0;
            r_first_fail <= 4'd0;
            r_pass       <= 1'b0;
        end else if (w_accept) begin
            r_index      <= 4'd0;
            r_cnt        <= 4'd0;
            r_exp        <= expected;
            r_table      <= 16'd0;
            r_mism       <= 5'd0;
            r_fail_valid <= 1'b0;
            r_first_fail <= 4'd0;
            r_pass       <= 1'b0;
        end else if (r_state == c_st_run) begin
            if (abort) begin
                // Partial results are kept; only the walk position resets.
                r_index <= 4'd0;
                r_cnt   <= 4'd0;
            end else if (w_sample) begin
                r_cnt            <= 4'd0;
                r_table[r_index] <= f;
                if (f != r_exp[r_index]) begin
                    r_mism <= r_mism + 5'd1;
                    if (!r_fail_valid) begin
                        r_first_fail <= r_index;
                        r_fail_valid <= 1'b1;
                    end
                end
                // Index 15 stays put for the done cycle.
                if (r_index != 4'hF) r_index <= r_index + 4'd1;
            end else begin
                r_cnt <= r_cnt + 4'd1;
            end
        end else if (r_state == c_st_done) begin
            r_pass  <= (r_mism == 5'd0);
            r_index <= 4'd0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ep01_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ep01_sweep_ctrl
// Description : Directed testbench for ep01_sweep_ctrl. One instance with
//               SETTLE=1 controls a selectable function (a&b or constant 1),
//               a second with SETTLE=3 controls a 4-input XOR.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ep01_sweep_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // SETTLE=1 instance
    logic        start1, abort1, f1, mode1;
    logic [15:0] exp1;
    logic        a1, b1, c1, d1, busy1, done1, fv1, pass1;
    logic [15:0] tab1;
    logic [4:0]  mism1;
    logic [3:0]  ff1;

    // SETTLE=3 instance
    logic        start3, abort3, f3;
    logic [15:0] exp3;
    logic        a3, b3, c3, d3, busy3, done3, fv3, pass3;
    logic [15:0] tab3;
    logic [4:0]  mism3;
    logic [3:0]  ff3;

    int n_vec = 0;
    int n_err = 0;
    int cyc;
    int n_done;
    int n_busy;

    // Function blocks under control
    always_comb f1 = mode1 ? 1'b1 : (a1 & b1);
    always_comb f3 = a3 ^ b3 ^ c3 ^ d3;

    ep01_sweep_ctrl #(.SETTLE(1)) u1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort1),
        .expected(exp1), .f(f1), .a(a1), .b(b1), .c(c1), .d(d1),
        .busy(busy1), .done(done1), .table_out(tab1), .mismatches(mism1),
        .fail_valid(fv1), .first_fail(ff1), .pass(pass1)
    );

    ep01_sweep_ctrl #(.SETTLE(3)) u3 (
        .clk(clk), .reset(reset), .start(start3), .abort(abort3),
        .expected(exp3), .f(f3), .a(a3), .b(b3), .c(c3), .d(d3),
        .busy(busy3), .done(done3), .table_out(tab3), .mismatches(mism3),
        .fail_valid(fv3), .first_fail(ff3), .pass(pass3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exv);
        n_vec++;
        assert (obs === exv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exv);
        end
    endtask

    // Pulse start on u1 and wait for done; returns the done cycle number
    // counted from the accepting edge (cycle 1 follows edge 0).
    task automatic sweep1(output int c);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        c = 1;
        while (!done1 && c < 100) begin
            tick();
            c++;
        end
    endtask

    initial begin
        reset = 1'b1;
        start1 = 1'b0; abort1 = 1'b0; exp1 = 16'h0; mode1 = 1'b0;
        start3 = 1'b0; abort3 = 1'b0; exp3 = 16'h0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // ---- reset state
        chk("rst_busy",  32'(busy1), 32'd0);
        chk("rst_done",  32'(done1), 32'd0);
        chk("rst_table", 32'(tab1),  32'd0);
        chk("rst_mism",  32'(mism1), 32'd0);
        chk("rst_fv",    32'(fv1),   32'd0);
        chk("rst_ff",    32'(ff1),   32'd0);
        chk("rst_pass",  32'(pass1), 32'd0);
        chk("rst_abcd",  32'({a1, b1, c1, d1}), 32'd0);

        // ---- f=a&b, matching expectation
        mode1 = 1'b0; exp1 = 16'hF000;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        cyc = 1;
        chk("t1_busy_c1", 32'(busy1), 32'd1);
        chk("t1_abcd_c1", 32'({a1, b1, c1, d1}), 32'd0);
        tick(); cyc++;
        chk("t1_abcd_c2", 32'({a1, b1, c1, d1}), 32'd1);
        while (!done1 && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("t1_done_cyc", 32'(cyc), 32'd17);
        chk("t1_busy_done", 32'(busy1), 32'd0);
        chk("t1_table", 32'(tab1), 32'hF000);
        chk("t1_mism", 32'(mism1), 32'd0);
        chk("t1_fv", 32'(fv1), 32'd0);
        chk("t1_pass", 32'(pass1), 32'd1);
        tick();
        chk("t1_done_pulse", 32'(done1), 32'd0);
        chk("t1_pass_hold", 32'(pass1), 32'd1);

        // ---- f=a&b, expectation differs at bits 0 and 7
        exp1 = 16'hF081;
        sweep1(cyc);
        chk("t2_done_cyc", 32'(cyc), 32'd17);
        chk("t2_table", 32'(tab1), 32'hF000);
        chk("t2_mism", 32'(mism1), 32'd2);
        chk("t2_ff", 32'(ff1), 32'd0);
        chk("t2_fv", 32'(fv1), 32'd1);
        chk("t2_pass_done", 32'(pass1), 32'd0);
        tick();
        chk("t2_pass_idle", 32'(pass1), 32'd0);

        // ---- SETTLE=3, xor parity
        exp3 = 16'h6996;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        cyc = 1;
        tick(); tick(); cyc = 3;
        chk("t3_abcd_c3", 32'({a3, b3, c3, d3}), 32'd0);
        tick(); cyc = 4;
        chk("t3_abcd_c4", 32'({a3, b3, c3, d3}), 32'd1);
        while (!done3 && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("t3_done_cyc", 32'(cyc), 32'd49);
        chk("t3_table", 32'(tab3), 32'h6996);
        chk("t3_pass", 32'(pass3), 32'd1);
        tick();

        // ---- start re-pulsed at cycles 5 and 17
        mode1 = 1'b0; exp1 = 16'hF000;
        start1 = 1'b1;
        tick();
        n_done = 0;
        for (int k = 1; k <= 17; k++) begin
            start1 = (k == 5 || k == 17);
            if (done1) n_done++;
            if (k < 17) tick();
        end
        chk("t4_done_c17", 32'(done1), 32'd1);
        chk("t4_single_done", 32'(n_done), 32'd1);
        tick();
        chk("t4_busy_c18", 32'(busy1), 32'd0);
        chk("t4_done_c18", 32'(done1), 32'd0);
        // Start at cycle 18 is accepted; this sweep feeds the abort check
        mode1 = 1'b1; exp1 = 16'h0000;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("t4_restart_busy", 32'(busy1), 32'd1);
        chk("t4_restart_pass", 32'(pass1), 32'd0);

        // ---- abort at cycle 6 of the sweep
        repeat (5) tick();
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        chk("t5_busy", 32'(busy1), 32'd0);
        chk("t5_done", 32'(done1), 32'd0);
        chk("t5_table", 32'(tab1), 32'h001F);
        chk("t5_mism", 32'(mism1), 32'd5);
        chk("t5_ff", 32'(ff1), 32'd0);
        chk("t5_fv", 32'(fv1), 32'd1);
        chk("t5_pass", 32'(pass1), 32'd0);
        chk("t5_abcd", 32'({a1, b1, c1, d1}), 32'd0);
        n_done = 0;
        n_busy = 0;
        repeat (20) begin
            tick();
            if (done1) n_done++;
            if (busy1) n_busy++;
        end
        chk("t5_no_done", 32'(n_done), 32'd0);
        chk("t5_no_busy", 32'(n_busy), 32'd0);
        chk("t5_table_hold", 32'(tab1), 32'h001F);

        // ---- reset mid-sweep at cycle 9
        mode1 = 1'b1; exp1 = 16'h0000;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (8) tick();
        chk("t6_pre_table", 32'(tab1), 32'h00FF);
        chk("t6_pre_mism", 32'(mism1), 32'd8);
        #1 reset = 1'b1;
        #1;
        chk("t6_busy", 32'(busy1), 32'd0);
        chk("t6_table", 32'(tab1), 32'd0);
        chk("t6_mism", 32'(mism1), 32'd0);
        chk("t6_fv", 32'(fv1), 32'd0);
        chk("t6_abcd", 32'({a1, b1, c1, d1}), 32'd0);
        chk("t6_pass", 32'(pass1), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        n_busy = 0;
        repeat (20) begin
            tick();
            if (busy1) n_busy++;
        end
        chk("t6_stay_idle", 32'(n_busy), 32'd0);
        mode1 = 1'b0; exp1 = 16'hF000;
        sweep1(cyc);
        chk("t6_done_cyc", 32'(cyc), 32'd17);
        chk("t6_table_after", 32'(tab1), 32'hF000);
        chk("t6_pass_after", 32'(pass1), 32'd1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
